jkff_bank_sequencer: RTL and testbench
======================================

Name: jkff_bank_sequencer

Overview:
Command-driven controller that sequences a WIDTH-bit register built from JK flip-flop cells. Each bit's J/K pair is generated per cycle to implement hold, clear, load, toggle-mask and multi-cycle synchronous up/down counting. It sits between a command source (FSM or testbench) and the JK register bank. It exposes the register value plus busy, done and wrap status.

Parameters:
WIDTH, 4, number of JK cells in the bank (register width)
STEP_W, 8, width of the step-count field for UP/DOWN commands

Ports:
clk  input  1  system clock, rising edge
asyncResetN  input  1  asynchronous active-low reset
cmdValid  input  1  command present
cmdReady  output  1  block can accept a command (high only in IDLE)
cmdOp  input  3  opcode: 0 HOLD, 1 CLEAR, 2 LOAD, 3 TOGGLE, 4 UP, 5 DOWN, 6-7 reserved
cmdData  input  WIDTH  LOAD value or TOGGLE mask
cmdSteps  input  STEP_W  count cycles for UP/DOWN; ignored otherwise
q  output  WIDTH  JK register contents
busy  output  1  high in EXEC and DONE
donePulse  output  1  one-cycle pulse marking command completion
wrapFlag  output  1  wrap occurred during the current or last command

Behaviour:
- Reset (asyncResetN=0, takes effect immediately, no clock needed): q=0, state=IDLE, cmdReady=1, busy=0, donePulse=0, wrapFlag=0, all J=K=0. Reset mid-command aborts it with no donePulse.
- FSM states are IDLE, EXEC and DONE.
- IDLE: cmdReady=1. On an edge with cmdValid=1, register op/data/steps and clear wrapFlag.
  - If the op is UP/DOWN with cmdSteps=0, go to DONE with q unchanged.
  - Otherwise go to EXEC with the remaining-step counter = cmdSteps for UP/DOWN, or 1 for all other ops.
- EXEC: drive J/K for one cycle per step. q updates on each edge. Decrement the counter. When the counter reaches 1 at an edge, go to DONE.
- DONE: donePulse=1, cmdReady=0 for exactly one cycle, then IDLE.
- Latency for single-cycle ops: accept edge T0, q updated at T1, donePulse high in cycle T1..T2, cmdReady high again after T2. Throughput is 1 command per 3 cycles.
- UP/DOWN with N steps gives N q updates, then donePulse.
- J/K generation in EXEC, per bit i:
  - HOLD and reserved ops 6/7: J=0, K=0.
  - CLEAR: J=0, K=1.
  - LOAD: J=data[i], K=~data[i].
  - TOGGLE: J=K=data[i].
  - UP: J=K=AND(q[i-1:0]), with bit0 always toggling.
  - DOWN: J=K=AND(~q[i-1:0]).
- Outside EXEC, J=K=0 for all bits; the bank holds.
- Arithmetic is modulo 2^WIDTH.
- wrapFlag is set on an UP edge where q was all-ones, or a DOWN edge where q was all-zeros. It is sticky until the next accept.
- cmdValid while cmdReady=0 is ignored. Nothing is latched and there is no error.
- cmdData, cmdOp and cmdSteps are sampled only at the accept edge. Later changes do not affect a running command.
- Each JK cell computes next = (J & ~Q) | (~K & Q), is clocked on clk, and is cleared by asyncResetN.

Decomposition:
- Shared package holds:
  - opcode localparams OP_HOLD..OP_DOWN
  - FSM state encoding for IDLE/EXEC/DONE
- One natural sub-module: jkff_async_reset, a single JK cell with asynchronous active-low clear and outputs Q/notQ. It is instantiated WIDTH times via generate.
- The FSM, step counter and J/K generation logic stay in jkff_bank_sequencer.

Test Plan:
1. Hold asyncResetN=0 for 2 cycles, then deassert between edges. -> q=0x0, cmdReady=1 and donePulse=0 during reset; q stays 0 with no clock activity.
2. Send LOAD cmdData=0xA. -> q=0xA one edge after accept, donePulse for one cycle the following cycle, wrapFlag=0, cmdReady back after DONE.
3. From q=0xA, send UP cmdSteps=7. -> q sequence B,C,D,E,F,0,1 on consecutive edges, wrapFlag=1, a single donePulse after the 7th update.
4. From q=0x1, send DOWN steps=3. -> q=0,F,E with wrapFlag=1. Then TOGGLE mask 0x5 gives q=0xB, and CLEAR gives q=0x0 with wrapFlag=0.
5. Pulse cmdValid with LOAD 0x3 while busy. -> ignored and q unchanged. UP with steps=0 -> donePulse with q unchanged. Reserved op 6 -> q unchanged and donePulse issued.
6. Assert asyncResetN low after the 3rd step of UP steps=10 from 0x0. -> q=0 immediately, no donePulse, cmdReady=1 after release, and the next LOAD 0x7 works normally.

Source files
------------

// File: rtl/jkff_bank_sequencer_pkg.sv
// Shared opcode and FSM state definitions for the JK register-bank sequencer.
package jkff_bank_sequencer_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_UP     = 3'd4;
    localparam logic [2:0] OP_DOWN   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/jkff_async_reset.sv
// Single JK flip-flop cell with asynchronous active-low clear and complementary outputs.
module jkff_async_reset (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_notQ
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= 1'b0;
        else          r_q <= (i_j & ~r_q) | (~i_k & r_q);
    end

    assign o_q    = r_q;
    assign o_notQ = ~r_q;

endmodule

// File: rtl/jkff_bank_sequencer.sv
// Command-driven sequencer: an IDLE/EXEC/DONE FSM generates per-bit J/K drive for a
// bank of JK cells to hold, clear, load, toggle or count up/down for N steps.
module jkff_bank_sequencer
    import jkff_bank_sequencer_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              asyncResetN,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [2:0]        cmdOp,
    input  logic [WIDTH-1:0]  cmdData,
    input  logic [STEP_W-1:0] cmdSteps,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              donePulse,
    output logic              wrapFlag
);

    seq_state_t        r_state, w_state_nxt;
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_data;
    logic [STEP_W-1:0] r_cnt;
    logic              r_wrap;

    logic [WIDTH-1:0]  w_j, w_k, w_q, w_nq;
    logic [WIDTH-1:0]  w_carry, w_borrow;
    logic              w_accept, w_cmd_count, w_wrap_evt;

    assign w_accept    = (r_state == ST_IDLE) && cmdValid;
    assign w_cmd_count = (cmdOp == OP_UP) || (cmdOp == OP_DOWN);

    always_ff @(posedge clk or negedge asyncResetN) begin
        if (!asyncResetN) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmdValid)
                    w_state_nxt = (w_cmd_count && (cmdSteps == '0)) ? ST_DONE : ST_EXEC;
            end
            ST_EXEC: begin
                if (r_cnt == STEP_W'(1)) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command fields are captured only at accept so later input changes cannot disturb a running op.
    always_ff @(posedge clk or negedge asyncResetN) begin
        if (!asyncResetN) begin
            r_op   <= OP_HOLD;
            r_data <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_accept) begin
            r_op   <= cmdOp;
            r_data <= cmdData;
            r_cnt  <= w_cmd_count ? cmdSteps : STEP_W'(1);
            r_wrap <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_cnt <= r_cnt - STEP_W'(1);
            if (w_wrap_evt) r_wrap <= 1'b1;
        end
    end

    // Ripple-free toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin : toggle_enables
        logic c;
        logic b;
        w_carry  = '0;
        w_borrow = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = 1'b1;
            b = 1'b1;
            for (int n = 0; n < i; n++) begin
                c = c & w_q[n];
                b = b & w_nq[n];
            end
            w_carry[i]  = c;
            w_borrow[i] = b;
        end
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                OP_CLEAR:  w_k = '1;
                OP_LOAD: begin
                    w_j = r_data;
                    w_k = ~r_data;
                end
                OP_TOGGLE: begin
                    w_j = r_data;
                    w_k = r_data;
                end
                OP_UP: begin
                    w_j = w_carry;
                    w_k = w_carry;
                end
                OP_DOWN: begin
                    w_j = w_borrow;
                    w_k = w_borrow;
                end
                default: begin
                    w_j = '0;
                    w_k = '0;
                end
            endcase
        end
    end

    assign w_wrap_evt = (r_state == ST_EXEC) &&
                        (((r_op == OP_UP) && (&w_q)) || ((r_op == OP_DOWN) && (&w_nq)));

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jkff_async_reset u_cell (
            .i_clk   (clk),
            .i_rst_n (asyncResetN),
            .i_j     (w_j[g]),
            .i_k     (w_k[g]),
            .o_q     (w_q[g]),
            .o_notQ  (w_nq[g])
        );
    end

    assign q         = w_q;
    assign cmdReady  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign donePulse = (r_state == ST_DONE);
    assign wrapFlag  = r_wrap;

endmodule

// File: tb/tb_jkff_bank_sequencer.sv
// Directed bench for jkff_bank_sequencer: reset, load, count with wrap, toggle/clear,
// ignored commands, zero-step and reserved ops, and mid-command reset abort.
module tb_jkff_bank_sequencer;

    logic       clk = 1'b0;
    logic       asyncResetN;
    logic       cmdValid;
    logic       cmdReady;
    logic [2:0] cmdOp;
    logic [3:0] cmdData;
    logic [7:0] cmdSteps;
    logic [3:0] q;
    logic       busy;
    logic       donePulse;
    logic       wrapFlag;

    int errors = 0;
    int checks = 0;

    jkff_bank_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
        .clk         (clk),
        .asyncResetN (asyncResetN),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdOp       (cmdOp),
        .cmdData     (cmdData),
        .cmdSteps    (cmdSteps),
        .q           (q),
        .busy        (busy),
        .donePulse   (donePulse),
        .wrapFlag    (wrapFlag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge, then scramble the fields to prove they are not re-sampled.
    task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [7:0] s);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = d;
        cmdSteps = s;
        tick();
        cmdValid = 1'b0;
        cmdOp    = 3'd1;
        cmdData  = ~d;
        cmdSteps = 8'd0;
    endtask

    initial begin
        logic [3:0] up_seq [7];
        logic [3:0] dn_seq [3];
        up_seq = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        dn_seq = '{4'h0, 4'hF, 4'hE};

        asyncResetN = 1'b0;
        cmdValid    = 1'b0;
        cmdOp       = 3'd0;
        cmdData     = 4'h0;
        cmdSteps    = 8'd0;

        // 1: reset
        tick();
        tick();
        chk("rst_q", q, 4'h0);
        chk("rst_ready", cmdReady, 1'b1);
        chk("rst_done", donePulse, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wrap", wrapFlag, 1'b0);
        asyncResetN = 1'b1;
        tick();
        chk("post_rst_q", q, 4'h0);
        chk("post_rst_ready", cmdReady, 1'b1);

        // 2: LOAD 0xA
        issue(3'd2, 4'hA, 8'd9);
        chk("load_busy", busy, 1'b1);
        chk("load_ready_lo", cmdReady, 1'b0);
        chk("load_q_pre", q, 4'h0);
        tick();
        chk("load_q", q, 4'hA);
        chk("load_done", donePulse, 1'b1);
        chk("load_wrap", wrapFlag, 1'b0);
        tick();
        chk("load_done_lo", donePulse, 1'b0);
        chk("load_ready", cmdReady, 1'b1);
        chk("load_q_hold", q, 4'hA);

        // 3: UP 7 from 0xA, wraps F->0 on the 6th edge
        issue(3'd4, 4'h0, 8'd7);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("up_q%0d", i), q, up_seq[i]);
            chk($sformatf("up_done%0d", i), donePulse, (i == 6) ? 1'b1 : 1'b0);
            chk($sformatf("up_wrap%0d", i), wrapFlag, (i >= 5) ? 1'b1 : 1'b0);
        end
        tick();
        chk("up_ready", cmdReady, 1'b1);
        chk("up_wrap_sticky", wrapFlag, 1'b1);

        // 4: DOWN 3 from 0x1, then TOGGLE 0x5, then CLEAR
        issue(3'd5, 4'h0, 8'd3);
        chk("dn_wrap_clr", wrapFlag, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("dn_q%0d", i), q, dn_seq[i]);
            chk($sformatf("dn_done%0d", i), donePulse, (i == 2) ? 1'b1 : 1'b0);
        end
        chk("dn_wrap", wrapFlag, 1'b1);
        tick();
        issue(3'd3, 4'h5, 8'd0);
        tick();
        chk("tog_q", q, 4'hB);
        chk("tog_done", donePulse, 1'b1);
        tick();
        issue(3'd1, 4'hF, 8'd0);
        tick();
        chk("clr_q", q, 4'h0);
        chk("clr_wrap", wrapFlag, 1'b0);
        tick();

        // 5: LOAD 0x3 offered while busy is ignored
        issue(3'd4, 4'h0, 8'd2);
        cmdValid = 1'b1;
        cmdOp    = 3'd2;
        cmdData  = 4'h3;
        tick();
        chk("busy_q1", q, 4'h1);
        tick();
        chk("busy_q2", q, 4'h2);
        chk("busy_done", donePulse, 1'b1);
        cmdValid = 1'b0;
        tick();
        chk("busy_idle", cmdReady, 1'b1);
        tick();
        chk("busy_ignored_q", q, 4'h2);
        chk("busy_ignored_busy", busy, 1'b0);

        issue(3'd4, 4'h0, 8'd0);
        chk("zero_done", donePulse, 1'b1);
        chk("zero_q", q, 4'h2);
        tick();
        chk("zero_ready", cmdReady, 1'b1);
        chk("zero_q_after", q, 4'h2);

        issue(3'd6, 4'hF, 8'd5);
        chk("rsv_busy", busy, 1'b1);
        tick();
        chk("rsv_q", q, 4'h2);
        chk("rsv_done", donePulse, 1'b1);
        tick();
        chk("rsv_ready", cmdReady, 1'b1);

        // 6: reset during UP 10 after the 3rd step
        issue(3'd1, 4'h0, 8'd0);
        tick();
        tick();
        issue(3'd4, 4'h0, 8'd10);
        tick();
        tick();
        tick();
        chk("abort_q_pre", q, 4'h3);
        asyncResetN = 1'b0;
        #1;
        chk("abort_q", q, 4'h0);
        chk("abort_done", donePulse, 1'b0);
        chk("abort_ready", cmdReady, 1'b1);
        tick();
        tick();
        chk("abort_q_hold", q, 4'h0);
        asyncResetN = 1'b1;
        tick();
        chk("abort_idle_done", donePulse, 1'b0);
        chk("abort_idle_ready", cmdReady, 1'b1);
        chk("abort_idle_q", q, 4'h0);
        issue(3'd2, 4'h7, 8'd0);
        tick();
        chk("relload_q", q, 4'h7);
        chk("relload_done", donePulse, 1'b1);
        tick();
        chk("relload_ready", cmdReady, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
